// File: rtl/led_blinker.sv
// Blinks led_out a requested number of times with exact on/off cycle counts, then pulses done_out.
// Define LED_BLINKER_ACTIVE_LOW_EN to drive led_out active-low; timing is identical in both builds.
module led_blinker #(
    parameter int CLK_MHZ = 8,
    parameter int ON_MS   = 100,
    parameter int OFF_MS  = 100
) (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic       start_in,
    input  logic [3:0] count_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       led_out
);
    // Phase lengths in clock cycles.
    localparam longint ON_CYC  = longint'(ON_MS) * longint'(CLK_MHZ) * 64'd1000;
    localparam longint OFF_CYC = longint'(OFF_MS) * longint'(CLK_MHZ) * 64'd1000;
    localparam longint MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;

    // The down-counter only ever holds (phase - 1) down to 0.
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYC - 1);

`ifdef LED_BLINKER_ACTIVE_LOW_EN
    localparam logic LED_LIT  = 1'b0;
    localparam logic LED_DARK = 1'b1;
`else
    localparam logic LED_LIT  = 1'b1;
    localparam logic LED_DARK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       rem_q;
    logic             led_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            led_q   <= LED_DARK;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        if (count_in != 4'd0) begin
                            state_q <= ST_ON;
                            rem_q   <= count_in;
                            cnt_q   <= ON_LOAD;
                            led_q   <= LED_LIT;
                            busy_q  <= 1'b1;
                        end else begin
                            // Zero-blink request completes immediately.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_OFF;
                        cnt_q   <= OFF_LOAD;
                        rem_q   <= rem_q - 4'd1;
                        led_q   <= LED_DARK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cnt_q == '0) begin
                        if (rem_q != 4'd0) begin
                            state_q <= ST_ON;
                            cnt_q   <= ON_LOAD;
                            led_q   <= LED_LIT;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= LED_DARK;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_out  = led_q;
    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker at CLK_MHZ=1, ON_MS=1, OFF_MS=2 (ON=1000, OFF=2000 cycles).
// Honours LED_BLINKER_ACTIVE_LOW_EN by complementing the expected led level.
module tb_led_blinker;
    localparam int ON  = 1000;
    localparam int OFF = 2000;
    localparam int PER = ON + OFF;

`ifdef LED_BLINKER_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cnt   = 4'd0;
    logic       busy;
    logic       done;
    logic       led;

    int n_vec = 0;
    int n_err = 0;

    led_blinker #(
        .CLK_MHZ(1),
        .ON_MS  (1),
        .OFF_MS (2)
    ) dut (
        .clock_in  (clk),
        .reset_n_in(rst_n),
        .start_in  (start),
        .count_in  (cnt),
        .busy_out  (busy),
        .done_out  (done),
        .led_out   (led)
    );

    always #5 clk = ~clk;

    // One request: inputs plus the expected blink count and done cycle (0 = never).
    typedef struct {
        string      name;
        int         gap;
        logic [3:0] cnt;
        int         pulse_at;
        int         rst_at;
        int         exp_blinks;
        int         exp_done_at;
        int         last;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {led (active-high), busy, done} k cycles after an accepted start.
    function automatic logic [2:0] model(int blinks, int done_at, int k);
        logic b;
        logic l;
        b = (k >= 1) && (k <= blinks * PER);
        l = b && (((k - 1) % PER) < ON);
        return {l, b, (k == done_at)};
    endfunction

    task automatic check(string name, int k, logic [2:0] exp);
        logic [2:0] want;
        want = {exp[2] ^ LED_INV, exp[1], exp[0]};
        n_vec++;
        if ({led, busy, done} !== want) begin
            n_err++;
            $display("FAIL %s k=%0d: led/busy/done got %b%b%b want %b", name, k, led, busy, done, want);
        end
        n_vec++;
        if ((busy & done) !== 1'b0) begin
            n_err++;
            $display("FAIL %s_excl k=%0d: busy=%b done=%b both high", name, k, busy, done);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [2:0] exp;
        for (int g = 1; g <= v.gap; g++) begin
            step();
            check({v.name, "_gap"}, -g, 3'b000);
        end
        start = 1'b1;
        cnt   = v.cnt;
        for (int k = 1; k <= v.last; k++) begin
            step();
            if (v.rst_at > 0 && k > v.rst_at) exp = 3'b000;
            else exp = model(v.exp_blinks, v.exp_done_at, k);
            check(v.name, k, exp);
            start = (k == v.pulse_at);
            cnt   = (k == v.pulse_at) ? 4'd5 : ~v.cnt;
            rst_n = !(k == v.rst_at);
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"cnt3",      0, 4'd3,    0,    0,  3,  9001,  9003};
        vecs[1] = '{"cnt0",      0, 4'd0,    0,    0,  0,     1,     3};
        vecs[2] = '{"ignore",    0, 4'd1,  500,    0,  1,  3001,  3100};
        vecs[3] = '{"abort",     0, 4'd2,    0, 2500,  2,     0,  2501};
        vecs[4] = '{"postrst",   1, 4'd1,    0,    0,  1,  3001,  3002};
        vecs[5] = '{"cnt15",     0, 4'd15,   0,    0, 15, 45001, 45002};

        // Reset holds outputs idle even with a start pending.
        rst_n = 1'b0;
        start = 1'b1;
        cnt   = 4'd3;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("reset", i, 3'b000);
        end
        start = 1'b0;
        rst_n = 1'b1;

        // First vector starts in the very first cycle out of reset.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // start_in held high: second request accepted in the IDLE cycle after DONE.
        start = 1'b1;
        cnt   = 4'd1;
        for (int k = 1; k <= 4003; k++) begin
            step();
            if (k <= 3002) check("b2b", k, model(1, 3001, k));
            else check("b2b", k, model(1, 3001, k - 3002));
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
- REQ-001: Parameter CLK_MHZ, default 8: clock frequency in MHz.
- REQ-002: Parameter ON_MS, default 100: LED on-time per blink, in ms; legal range 1 or more.
- REQ-003: Parameter OFF_MS, default 100: LED off-time after each blink, in ms; legal range 1 or more.
- REQ-004: clock_in, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-005: reset_n_in, input, 1 bit: synchronous, active-low reset.
- REQ-006: start_in, input, 1 bit: request strobe; sampled every cycle.
- REQ-007: count_in, input, 4 bits: number of blinks requested (0-15); sampled only when a start is accepted.
- REQ-008: busy_out, output, 1 bit: high while a blink sequence is in progress.
- REQ-009: done_out, output, 1 bit: one-cycle completion pulse.
- REQ-010: led_out, output, 1 bit: LED drive, registered.

Function
- REQ-011: Phase lengths SHALL be exact cycle counts:
  - ON phase = ON_MS*CLK_MHZ*1000 cycles.
  - OFF phase = OFF_MS*CLK_MHZ*1000 cycles.
  - Counter width SHALL be the ceiling log2 of the larger phase count, with no overflow.
- REQ-012: The state machine SHALL have states IDLE, ON, OFF and DONE, and SHALL reset to IDLE.
- REQ-013: A start is accepted only when start_in=1 in IDLE; start_in in any other state SHALL be ignored and SHALL NOT be queued.
- REQ-014: Accepted start with count_in!=0 at cycle T:
  - count_in is latched.
  - The phase counter is reloaded.
  - At T+1: state ON, led_out=1, busy_out=1.
- REQ-015: ON to OFF after exactly one ON phase:
  - led_out=0 for exactly one OFF phase.
  - The remaining-blink count decrements at the ON-to-OFF transition.
- REQ-016: At the end of an OFF phase:
  - If the remaining count is nonzero, go to ON (next blink; no extra gap cycles).
  - Otherwise go to DONE.
- REQ-017: DONE SHALL last exactly one cycle, with done_out=1, busy_out=0 and led_out=0; the next state is IDLE.
- REQ-018: A start accepted in the cycle after DONE (IDLE) SHALL be honoured normally.
- REQ-019: Total busy time for N blinks SHALL be exactly N*(ON+OFF) cycles, followed by the done_out cycle.
- REQ-020: Accepted start with count_in=0:
  - No LED activity and busy_out stays 0.
  - The state machine goes to DONE, so done_out=1 at T+1.
- REQ-021: busy_out and done_out SHALL never be high in the same cycle.
- REQ-022: Changes on count_in while busy SHALL have no effect on the running sequence.

Reset
- REQ-023: While reset_n_in=0 at a rising edge, the next-cycle values SHALL be:
  - state IDLE.
  - led_out=0 (unasserted level, see REQ-026).
  - busy_out=0 and done_out=0.
  - Counters cleared.
- REQ-024: Reset asserted mid-sequence SHALL abort it with no done_out pulse.
- REQ-025: After reset_n_in returns to 1, the block SHALL accept a start in the first cycle.

Configuration
- REQ-026: Macro LED_BLINKER_ACTIVE_LOW_EN controls led_out polarity:
  - Defined: led_out is active-low; it is 1 in reset, IDLE, OFF and DONE, and 0 in ON.
  - Undefined: led_out is active-high, as described above.
  - All other outputs and all timing SHALL be identical in both builds.

Verification (CLK_MHZ=1, ON_MS=1, OFF_MS=2: ON=1000 cycles, OFF=2000 cycles)
- REQ-027: Start with count_in=3 at cycle T:
  - led_out high during T+1..T+1000, T+3001..T+4000 and T+6001..T+7000, low elsewhere.
  - busy_out high during T+1..T+9000.
  - done_out high only at T+9001.
- REQ-028: Start with count_in=0 at cycle T -> done_out high at T+1 only; busy_out and led_out stay 0 throughout.
- REQ-029: Start with count_in=1, then start_in pulsed with count_in=5 at T+500 -> a single blink only; done_out at T+3001; no second sequence.
- REQ-030: Start with count_in=2, then reset_n_in=0 for 1 cycle at T+2500:
  - All outputs 0 from T+2501.
  - No done_out pulse.
  - A new start at T+2502 with count_in=1 produces led_out high during T+2503..T+3502.
- REQ-031: Back-to-back requests: count_in=1 at T, and start_in held high continuously -> the second sequence is accepted at T+3002 (IDLE after DONE), with led_out high from T+3003.
- REQ-032: Build with LED_BLINKER_ACTIVE_LOW_EN and repeat REQ-027 -> led_out is the exact complement of REQ-027 (including 1 during reset); busy_out and done_out are unchanged.
